rom_cycle_ctrl: RTL and testbench

Bus-side front end for the boot/flash ROM window on the card. It decodes the ROM address window on the host bus, opens and closes `romcycle` for the parallel flash stage, and consumes that stage's `dtack`. It converts `dtack` into the card-level `DTACK_n` handshake. It also enforces bus recovery and a watchdog timeout so a stalled ROM access cannot hang the bus.

---
 rtl/rom_cycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_rom_cycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_cycle_ctrl.sv
// ROM window front end: decodes the host-bus ROM window, frames romcycle for the
// flash stage, turns its dtack into DTACK_n, and guards the bus with recovery and timeout.
module rom_cycle_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int RECOVERY = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              AS_n,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [ADDR_W-1:0] BASE,
   input  logic              CONFIGURED,
   input  logic              rom_dtack,
   output logic              romcycle,
   output logic              DTACK_n,
   output logic              BERR_n,
   output logic              busy
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
   localparam logic [3:0]       REC_LOAD = 4'(RECOVERY - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_ACK,
      ST_ERR,
      ST_RECOVER
   } state_t;

   state_t           state_reg, state_next;
   logic             as_meta_reg, as_sync_reg;
   logic             as_s;
   logic             hit;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [3:0]       rec_cnt_reg, rec_cnt_next;
   logic             armed_reg, armed_next;
   logic             romcycle_reg, romcycle_next;
   logic             dtack_n_reg, dtack_n_next;
   logic             berr_n_reg, berr_n_next;
   logic             busy_reg, busy_next;

   // AS_n is asynchronous to CLK; reset to the deasserted level so no strobe is seen.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         as_meta_reg <= 1'b1;
         as_sync_reg <= 1'b1;
      end else begin
         as_meta_reg <= AS_n;
         as_sync_reg <= as_meta_reg;
      end
   end

   assign as_s = ~as_sync_reg;
   assign hit  = CONFIGURED && (ADDR == BASE);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg    <= ST_IDLE;
         tmo_cnt_reg  <= '0;
         rec_cnt_reg  <= '0;
         armed_reg    <= 1'b1;
         romcycle_reg <= 1'b0;
         dtack_n_reg  <= 1'b1;
         berr_n_reg   <= 1'b1;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         rec_cnt_reg  <= rec_cnt_next;
         armed_reg    <= armed_next;
         romcycle_reg <= romcycle_next;
         dtack_n_reg  <= dtack_n_next;
         berr_n_reg   <= berr_n_next;
         busy_reg     <= busy_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      tmo_cnt_next = tmo_cnt_reg;
      rec_cnt_next = rec_cnt_reg;
      // Re-arm whenever the strobe is seen idle, so one long strobe is accepted once.
      armed_next   = armed_reg | ~as_s;

      case (state_reg)
         ST_IDLE: begin
            if (as_s && hit && armed_reg) begin
               state_next   = ST_ACTIVE;
               tmo_cnt_next = '0;
               armed_next   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            if (tmo_cnt_reg != TMO_MAX) begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
            if (rom_dtack) begin
               state_next = ST_ACK;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               state_next = ST_ERR;
            end else if (!as_s) begin
               state_next   = ST_RECOVER;
               rec_cnt_next = REC_LOAD;
            end
         end
         ST_ACK, ST_ERR: begin
            if (!as_s) begin
               state_next   = ST_RECOVER;
               rec_cnt_next = REC_LOAD;
            end
         end
         ST_RECOVER: begin
            if (rec_cnt_reg == 4'd0) begin
               state_next = ST_IDLE;
            end else begin
               rec_cnt_next = rec_cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change in the same registered update.
   always_comb begin
      romcycle_next = (state_next == ST_ACTIVE) || (state_next == ST_ACK);
      dtack_n_next  = (state_next != ST_ACK);
      berr_n_next   = (state_next != ST_ERR);
      busy_next     = (state_next != ST_IDLE);
   end

   assign romcycle = romcycle_reg;
   assign DTACK_n  = dtack_n_reg;
   assign BERR_n   = berr_n_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_rom_cycle_ctrl.sv
// Directed bench for rom_cycle_ctrl: a cycle-level access model checked every clock,
// plus literal latency/pulse expectations for each scenario.
module tb_rom_cycle_ctrl;

   localparam int ADDR_W   = 8;
   localparam int RECOVERY = 2;
   localparam int TIMEOUT  = 64;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              AS_n;
   logic [ADDR_W-1:0] ADDR;
   logic [ADDR_W-1:0] BASE;
   logic              CONFIGURED;
   logic              rom_dtack;
   logic              romcycle;
   logic              DTACK_n;
   logic              BERR_n;
   logic              busy;

   int checks = 0;
   int errors = 0;

   rom_cycle_ctrl #(
      .ADDR_W  (ADDR_W),
      .RECOVERY(RECOVERY),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .AS_n      (AS_n),
      .ADDR      (ADDR),
      .BASE      (BASE),
      .CONFIGURED(CONFIGURED),
      .rom_dtack (rom_dtack),
      .romcycle  (romcycle),
      .DTACK_n   (DTACK_n),
      .BERR_n    (BERR_n),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   // Access model: strobe seen two clocks late; an access is open, acked or
   // errored; after it closes the bus rests for RECOVERY clocks.
   bit m_d1 = 1'b0, m_d2 = 1'b0, m_s, m_hit;
   bit m_armed = 1'b1, m_access = 1'b0, m_acked = 1'b0, m_err = 1'b0;
   int m_age = 0, m_rec = 0;
   logic exp_romcycle = 1'b0, exp_dtack_n = 1'b1, exp_berr_n = 1'b1, exp_busy = 1'b0;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_d1 = 1'b0; m_d2 = 1'b0; m_armed = 1'b1;
         m_access = 1'b0; m_acked = 1'b0; m_err = 1'b0;
         m_age = 0; m_rec = 0;
      end else begin
         m_s   = m_d2;
         m_d2  = m_d1;
         m_d1  = !AS_n;
         m_hit = CONFIGURED && (ADDR == BASE);
         if (!m_s) m_armed = 1'b1;
         if (m_access) begin
            if (m_acked || m_err) begin
               if (!m_s) begin
                  m_access = 1'b0; m_acked = 1'b0; m_err = 1'b0; m_rec = RECOVERY;
               end
            end else begin
               m_age++;
               if (rom_dtack) m_acked = 1'b1;
               else if (m_age == TIMEOUT) m_err = 1'b1;
               else if (!m_s) begin
                  m_access = 1'b0; m_rec = RECOVERY;
               end
            end
         end else if (m_rec > 0) begin
            m_rec--;
         end else if (m_s && m_hit && m_armed) begin
            m_access = 1'b1; m_age = 0; m_armed = 1'b0;
         end
      end
      exp_romcycle = m_access && !m_err;
      exp_dtack_n  = !(m_access && m_acked);
      exp_berr_n   = !(m_access && m_err);
      exp_busy     = m_access || (m_rec > 0);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare all outputs against the model on the falling edge,
   // then return just after the next rising edge.
   task automatic step();
      @(negedge CLK);
      checks++;
      if ({romcycle, DTACK_n, BERR_n, busy} !== {exp_romcycle, exp_dtack_n, exp_berr_n, exp_busy}) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t got rc=%b dt=%b be=%b bz=%b, expected rc=%b dt=%b be=%b bz=%b",
                  $time, romcycle, DTACK_n, BERR_n, busy,
                  exp_romcycle, exp_dtack_n, exp_berr_n, exp_busy);
      end
      @(posedge CLK);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return romcycle;
         1:       return DTACK_n;
         2:       return BERR_n;
         default: return busy;
      endcase
   endfunction

   // Clocks until the selected output reaches val; -1 if the budget runs out.
   task automatic wait_sig(input int which, input logic val, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (sig(which) == val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_read(input string tag);
      int n;
      AS_n = 1'b0;
      wait_sig(0, 1'b1, 10, n);  chk({tag, "_romcycle_lat"}, n, 3);
      repeat (4) step();
      rom_dtack = 1'b1;
      wait_sig(1, 1'b0, 10, n);  chk({tag, "_dtack_lat"}, n, 1);
      rom_dtack = 1'b0;
      repeat (3) step();
      chk({tag, "_dtack_held"}, int'(DTACK_n), 0);
      AS_n = 1'b1;
      wait_sig(1, 1'b1, 10, n);  chk({tag, "_dtack_release"}, n, 3);
      chk({tag, "_romcycle_off"}, int'(romcycle), 0);
      wait_sig(3, 1'b0, 10, n);  chk({tag, "_busy_idle"}, n, RECOVERY);
   endtask

   task automatic miss_run(input string tag);
      int seen;
      seen = 0;
      AS_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (romcycle || !DTACK_n || !BERR_n || busy) seen++;
      end
      chk(tag, seen, 0);
      AS_n = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int falls;
      logic prev;

      RESET = 1'b1; AS_n = 1'b1; ADDR = 8'h00; BASE = 8'h20;
      CONFIGURED = 1'b0; rom_dtack = 1'b0;
      step(); step();
      chk("reset_romcycle", int'(romcycle), 0);
      chk("reset_dtack_n", int'(DTACK_n), 1);
      chk("reset_berr_n", int'(BERR_n), 1);
      chk("reset_busy", int'(busy), 0);
      RESET = 1'b0;
      step();

      // Read hit at 0x20
      CONFIGURED = 1'b1; ADDR = 8'h20;
      do_read("read");

      // Miss, then unconfigured
      ADDR = 8'h21;
      miss_run("miss_addr_quiet");
      CONFIGURED = 1'b0; ADDR = 8'h20;
      miss_run("miss_unconfig_quiet");
      CONFIGURED = 1'b1;
      step();

      // Timeout with rom_dtack held low
      AS_n = 1'b0;
      wait_sig(0, 1'b1, 10, n);   chk("tmo_romcycle_lat", n, 3);
      wait_sig(2, 1'b0, 100, n);  chk("tmo_berr_lat", n, TIMEOUT);
      chk("tmo_romcycle_off", int'(romcycle), 0);
      repeat (3) step();
      AS_n = 1'b1;
      wait_sig(2, 1'b1, 10, n);   chk("tmo_berr_release", n, 3);
      wait_sig(3, 1'b0, 10, n);   chk("tmo_busy_idle", n, RECOVERY);

      // Bus abort two clocks into ACTIVE
      AS_n = 1'b0;
      wait_sig(0, 1'b1, 10, n);   chk("abort_romcycle_lat", n, 3);
      repeat (2) step();
      AS_n = 1'b1;
      wait_sig(0, 1'b0, 10, n);   chk("abort_romcycle_fall", n, 3);
      chk("abort_no_dtack", int'(DTACK_n), 1);
      chk("abort_no_berr", int'(BERR_n), 1);
      wait_sig(3, 1'b0, 10, n);   chk("abort_recover_len", n, RECOVERY);

      // Back-to-back: second strobe lands while RECOVER is running
      AS_n = 1'b0;
      wait_sig(0, 1'b1, 10, n);   chk("b2b_first_lat", n, 3);
      rom_dtack = 1'b1;
      wait_sig(1, 1'b0, 10, n);   chk("b2b_first_dtack", n, 1);
      rom_dtack = 1'b0;
      AS_n = 1'b1;
      step();
      AS_n = 1'b0;
      wait_sig(1, 1'b1, 10, n);   chk("b2b_first_release", n, 2);
      wait_sig(0, 1'b1, 10, n);   chk("b2b_second_after_idle", n, RECOVERY + 1);
      rom_dtack = 1'b1;
      wait_sig(1, 1'b0, 10, n);   chk("b2b_second_dtack", n, 1);
      rom_dtack = 1'b0;
      AS_n = 1'b1;
      wait_sig(3, 1'b0, 10, n);   chk("b2b_busy_idle", n, 3 + RECOVERY);

      // Long strobe with a stuck-high rom_dtack: exactly one DTACK_n pulse
      BASE = 8'hA5; ADDR = 8'hA5;
      AS_n = 1'b0;
      wait_sig(0, 1'b1, 10, n);   chk("long_romcycle_lat", n, 3);
      rom_dtack = 1'b1;
      falls = 0;
      prev = DTACK_n;
      for (int i = 0; i < 52; i++) begin
         if (i == 40) AS_n = 1'b1;
         step();
         if (prev && !DTACK_n) falls++;
         prev = DTACK_n;
      end
      rom_dtack = 1'b0;
      chk("long_one_dtack", falls, 1);
      chk("long_busy_idle", int'(busy), 0);

      // Asynchronous reset while in ACK
      AS_n = 1'b0;
      wait_sig(0, 1'b1, 10, n);   chk("areset_romcycle_lat", n, 3);
      rom_dtack = 1'b1;
      wait_sig(1, 1'b0, 10, n);   chk("areset_dtack_lat", n, 1);
      rom_dtack = 1'b0;
      #2 RESET = 1'b1;
      #1;
      chk("areset_dtack_n", int'(DTACK_n), 1);
      chk("areset_romcycle", int'(romcycle), 0);
      chk("areset_berr_n", int'(BERR_n), 1);
      chk("areset_busy", int'(busy), 0);
      AS_n = 1'b1;
      step(); step();
      RESET = 1'b0;
      step();
      do_read("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
